inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch sequencer for the five-stage pipelined CPU. Owns the program counter and drives the combinational instruction memory's address. Captures the returned word into the IF/ID pipeline register. Applies hazard-unit stalls, branch/jump redirects with flush, and halts fetch when the PC leaves the loaded program range.

## Interface
- `RESET_PC`, default 32'd0: PC value after reset.
- `LAST_PC`, default 32'd64: highest valid instruction address. PC > `LAST_PC` halts fetch.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `imem_addr`, output, 32: address to instruction memory; equals the current PC.
- `imem_instr`, input, 32: instruction word, combinational from `imem_addr` in the same cycle.
- `stall_i`, input, 1: hazard-unit stall; hold PC and IF/ID.
- `redirect_i`, input, 1: taken branch/jump resolved; flush and reload the PC.
- `redirect_pc_i`, input, 32: redirect target.
- `ifid_instr_o`, output, 32: IF/ID instruction.
- `ifid_pc4_o`, output, 32: IF/ID PC+4.
- `ifid_valid_o`, output, 1: IF/ID holds a real instruction.
- `halted_o`, output, 1: state is HALT or ERR.
- `err_o`, output, 1: sticky misaligned-redirect error.
- `fetch_cnt_o`, output, 32: count of valid instructions written into IF/ID; wraps at 2^32.

## Operation
States and their behaviour:
- **BOOT**:
  - Entered on reset.
  - Outputs a bubble; PC stays at `RESET_PC`.
  - Always moves to RUN next cycle.
- **RUN**, apply the first matching rule, in this priority order:
  1. `redirect_i`:
     - If `redirect_pc_i[1:0]` != 0: enter ERR, load nothing, write a bubble to IF/ID.
     - Otherwise: PC <= `redirect_pc_i`, IF/ID <= bubble.
  2. `stall_i`: PC, IF/ID and `fetch_cnt_o` all hold.
  3. PC > `LAST_PC`: enter HALT, IF/ID <= bubble.
  4. Otherwise:
     - PC <= PC+4.
     - IF/ID <= {`imem_instr`, PC+4, valid=1}.
     - `fetch_cnt_o` increments.
- **HALT**:
  - PC holds; IF/ID holds a bubble every cycle so the pipeline drains.
  - An aligned `redirect_i` loads the PC and returns to RUN. This lets an in-flight branch pull fetch back into range.
  - A misaligned redirect enters ERR.
  - `stall_i` is ignored.
- **ERR**: terminal until `rst`; behaves as HALT with redirects ignored; `err_o`=1.
- **Bubble** means `ifid_instr_o`=32'h0000_0000 (nop), `ifid_pc4_o`=0, `ifid_valid_o`=0.
- **Simultaneous `redirect_i` and `stall_i`**: redirect wins. A flush always overrides a hold.
- **PC arithmetic**: 32-bit unsigned; PC+4 wraps modulo 2^32. The > `LAST_PC` comparison is unsigned.
- **`imem_addr`**: driven straight from the PC register with no extra logic after the register.

## Timing
- **Reset**:
  - `rst` high at edge t: from t+1 all outputs are 0, `imem_addr`=`RESET_PC`, state=BOOT.
  - `rst` asserted mid-operation discards any in-flight redirect or stall.
- **BOOT to first fetch**: first valid IF/ID word (from `RESET_PC`) appears two edges after reset deasserts.
- **Fetch latency**: one cycle. The word at PC in cycle t is on `ifid_instr_o` after edge t+1.
- **Redirect**:
  - `redirect_i` sampled at edge t: `imem_addr`=target after t.
  - IF/ID is a bubble after t; the target instruction is valid after t+1.
  - Exactly one bubble per redirect.
- **Stall**: held for N cycles produces exactly N cycles of identical IF/ID and `imem_addr`.
- **Halt**: `halted_o` rises the cycle after the edge at which PC > `LAST_PC` is detected.

## Structure
- Shared package `fetch_pkg`:
  - state enum {BOOT, RUN, HALT, ERR}
  - `NOP_INSTR`=32'h0
  - `PC_STEP`=32'd4
- One optional sub-module, `pc_next_sel`: combinational next-PC mux covering redirect, hold and +4.
- The state register, IF/ID register and counter stay in `inst_fetch_ctrl`.
- The instruction memory is instantiated externally, alongside this block, at the CPU top.

## Test plan
All scenarios use the standard program image: 0x00 holds 0x20020005, 0x04 holds 0x2003000c, 0x18 holds 0x10a7000a, 0x40 holds 0xac020054.

1. **Reset then free-run**:
   - Stimulus: `rst` for 2 cycles, then release.
   - Required: one bubble; then IF/ID = 0x20020005 / pc4 0x04, then 0x2003000c / 0x08.
   - Required: `fetch_cnt_o` increments per valid word.
2. **Stall for 3 cycles at PC 0x0C**:
   - Required: `imem_addr` stays 0x0C and IF/ID stays the 0x08 word for 3 cycles.
   - Required: resumes with the 0x0C word; count frozen during the stall.
3. **Redirect from PC 0x1C to 0x30**:
   - Required: one bubble (valid=0, instr 0).
   - Required: next IF/ID has pc4 0x34; no word from 0x1C or 0x20 is ever valid.
4. **Redirect and stall in the same cycle**:
   - Required: the redirect is taken; the stall has no effect.
5. **Run past 0x40**:
   - Required: the 0x40 word (0xac020054) is fetched; at PC 0x44 `halted_o`=1 and bubbles follow.
   - Required: an aligned redirect to 0x0C while halted resumes fetch at 0x0C.
6. **Misaligned redirect (0x0000_0006)**:
   - Required: `err_o`=`halted_o`=1.
   - Required: later redirects are ignored until `rst` clears ERR and PC returns to `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                sequencer: FSM state encoding, nop word, PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    // Encoding of what the IF/ID register does this cycle
    typedef enum logic [1:0] {
        IFID_BUBBLE = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_FETCH  = 2'd2
    } ifid_op_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Instruction addresses must be word aligned
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_ctrl_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selection: redirect target, hold,
//                or sequential PC+4 (wrapping modulo 2^32).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    input  logic        load_i,
    input  logic        advance_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc_i + PC_STEP;
    assign pc_plus4_o = w_pc_plus4;

    // Redirect has priority over sequential advance; otherwise hold
    always_comb begin
        pc_next_o = pc_i;
        if (load_i) begin
            pc_next_o = target_i;
        end else if (advance_i) begin
            pc_next_o = w_pc_plus4;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, drives the
//                combinational instruction memory address, captures the
//                returned word into IF/ID, and handles stall, redirect with
//                flush, end-of-program halt and misaligned-redirect error.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] LAST_PC  = 32'd64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic        err_o,
    output logic [31:0] fetch_cnt_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_plus4;

    logic [31:0]  r_ifid_instr;
    logic [31:0]  r_ifid_pc4;
    logic         r_ifid_valid;
    logic [31:0]  r_fetch_cnt;

    logic         w_load;
    logic         w_advance;
    logic         w_cnt_inc;
    ifid_op_e     w_ifid_op;

    logic         w_redirect_ok;
    logic         w_past_end;

    assign w_redirect_ok = is_aligned(redirect_pc_i);
    assign w_past_end    = (r_pc > LAST_PC);

    pc_next_sel u_pc_next_sel (
        .pc_i       (r_pc),
        .target_i   (redirect_pc_i),
        .load_i     (w_load),
        .advance_i  (w_advance),
        .pc_next_o  (w_pc_next),
        .pc_plus4_o (w_pc_plus4)
    );

    // Next-state and datapath controls; redirect outranks stall, stall
    // outranks the end-of-program check
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_ifid_op    = IFID_BUBBLE;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    if (w_redirect_ok) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ERR;
                    end
                end else if (stall_i) begin
                    w_ifid_op = IFID_HOLD;
                end else if (w_past_end) begin
                    w_state_next = HALT;
                end else begin
                    w_advance = 1'b1;
                    w_cnt_inc = 1'b1;
                    w_ifid_op = IFID_FETCH;
                end
            end
            HALT: begin
                // Stall is irrelevant here: nothing is being fetched
                if (redirect_i) begin
                    if (w_redirect_ok) begin
                        w_load       = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_state_next = ERR;
                    end
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID pipeline register: load fetched word, hold, or insert a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            case (w_ifid_op)
                IFID_FETCH: begin
                    r_ifid_instr <= imem_instr;
                    r_ifid_pc4   <= w_pc_plus4;
                    r_ifid_valid <= 1'b1;
                end
                IFID_HOLD: begin
                    r_ifid_instr <= r_ifid_instr;
                    r_ifid_pc4   <= r_ifid_pc4;
                    r_ifid_valid <= r_ifid_valid;
                end
                default: begin
                    r_ifid_instr <= NOP_INSTR;
                    r_ifid_pc4   <= 32'd0;
                    r_ifid_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count of valid words written into IF/ID, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_cnt_inc) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem_addr    = r_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_valid_o = r_ifid_valid;
    assign halted_o     = (r_state == HALT) || (r_state == ERR);
    assign err_o        = (r_state == ERR);
    assign fetch_cnt_o  = r_fetch_cnt;

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_ctrl
//  Description : Self-checking bench for inst_fetch_ctrl with a behavioural
//                reference model feeding an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'd0;
    localparam logic [31:0] C_LAST_PC  = 32'd64;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic        err_o;
    logic [31:0] fetch_cnt_o;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0 BOOT, 1 RUN, 2 HALT, 3 ERR
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_cnt;

    inst_fetch_ctrl #(
        .RESET_PC (C_RESET_PC),
        .LAST_PC  (C_LAST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o),
        .err_o         (err_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    // Program image; unlisted addresses return a tag of their own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h2002_0005;
            32'h04:  return 32'h2003_000c;
            32'h18:  return 32'h10a7_000a;
            32'h40:  return 32'hac02_0054;
            default: return {8'h13, a[23:0]};
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus, predict the result, then compare after the edge
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        rst           = r;
        stall_i       = s;
        redirect_i    = d;
        redirect_pc_i = t;
        if (r) begin
            m_state = 0; m_pc = C_RESET_PC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        end else begin
            case (m_state)
                0: begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                    m_state = 1;
                end
                1: begin
                    if (d) begin
                        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                        if (t[1:0] != 2'b00) m_state = 3;
                        else m_pc = t;
                    end else if (s) begin
                        // everything holds
                    end else if (m_pc > C_LAST_PC) begin
                        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                        m_state = 2;
                    end else begin
                        m_instr = mem_word(m_pc);
                        m_pc4   = m_pc + 32'd4;
                        m_valid = 1'b1;
                        m_pc    = m_pc + 32'd4;
                        m_cnt   = m_cnt + 32'd1;
                    end
                end
                2: begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                    if (d) begin
                        if (t[1:0] != 2'b00) m_state = 3;
                        else begin
                            m_pc = t;
                            m_state = 1;
                        end
                    end
                end
                default: begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end
            endcase
        end
        e.addr   = m_pc;
        e.instr  = m_instr;
        e.pc4    = m_pc4;
        e.valid  = m_valid;
        e.halted = (m_state >= 2);
        e.err    = (m_state == 3);
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr,              e.addr);
        chk("ifid_instr", ifid_instr_o,          e.instr);
        chk("ifid_pc4",   ifid_pc4_o,            e.pc4);
        chk("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, e.valid});
        chk("halted",     {31'h0, halted_o},     {31'h0, e.halted});
        chk("err",        {31'h0, err_o},        {31'h0, e.err});
        chk("fetch_cnt",  fetch_cnt_o,           e.cnt);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_cnt = 32'h0;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // 1. Reset for two cycles, then free-run
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid_o}, 32'h0);
        step(0, 0, 0, 0);
        chk("boot_bubble", {31'h0, ifid_valid_o}, 32'h0);
        step(0, 0, 0, 0);
        chk("first_word", ifid_instr_o, 32'h2002_0005);
        chk("first_pc4", ifid_pc4_o, 32'h04);
        chk("first_cnt", fetch_cnt_o, 32'd1);
        step(0, 0, 0, 0);
        chk("second_word", ifid_instr_o, 32'h2003_000c);
        chk("second_pc4", ifid_pc4_o, 32'h08);
        step(0, 0, 0, 0);

        // 2. Stall three cycles at PC 0x0C
        chk("pre_stall_addr", imem_addr, 32'h0C);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_addr", imem_addr, 32'h0C);
            chk("stall_pc4", ifid_pc4_o, 32'h0C);
            chk("stall_cnt", fetch_cnt_o, 32'd3);
        end
        step(0, 0, 0, 0);
        chk("resume_pc4", ifid_pc4_o, 32'h10);

        // 3. Run to PC 0x1C, then redirect to 0x30
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("pre_redir_addr", imem_addr, 32'h1C);
        step(0, 0, 1, 32'h30);
        chk("redir_bubble_v", {31'h0, ifid_valid_o}, 32'h0);
        chk("redir_bubble_i", ifid_instr_o, 32'h0);
        chk("redir_addr", imem_addr, 32'h30);
        step(0, 0, 0, 0);
        chk("redir_target_pc4", ifid_pc4_o, 32'h34);

        // 4. Redirect and stall together: redirect wins
        step(0, 1, 1, 32'h18);
        chk("rs_addr", imem_addr, 32'h18);
        step(0, 0, 0, 0);
        chk("rs_word", ifid_instr_o, 32'h10a7_000a);

        // 5. Run past LAST_PC, halt, then pull back with a redirect
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("last_word", ifid_instr_o, 32'hac02_0054);
        chk("last_pc4", ifid_pc4_o, 32'h44);
        step(0, 0, 0, 0);
        chk("halt_flag", {31'h0, halted_o}, 32'h1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0C);
        chk("unhalt_addr", imem_addr, 32'h0C);
        step(0, 0, 0, 0);
        chk("unhalt_pc4", ifid_pc4_o, 32'h10);

        // 6. Misaligned redirect locks into ERR until reset
        step(0, 0, 1, 32'h6);
        chk("err_flag", {31'h0, err_o}, 32'h1);
        step(0, 0, 1, 32'h20);
        step(0, 0, 1, 32'h10);
        chk("err_addr_hold", imem_addr, 32'h10);
        step(1, 1, 1, 32'h30);
        chk("err_cleared", {31'h0, err_o}, 32'h0);
        chk("rst_pc", imem_addr, C_RESET_PC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("refetch_word", ifid_instr_o, 32'h2002_0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl
`default_nettype wire
